// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: fetch FSM states and the fetch buffer entry.
// Width matches program_counter so {pc, instr} pairs stay aligned.
package cpu_pkg;
   localparam int WIDTH     = 32;
   localparam int BUF_DEPTH = 2;

   typedef enum logic {
      FETCH_REQ,
      FETCH_WAIT
   } fetch_state_t;

   typedef struct packed {
      logic [WIDTH-1:0] pc;
      logic [WIDTH-1:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch stage bus: imem request/response channel plus the decode-side output.
// master = fetch stage, slave = memory/decode side.
interface instruction_fetch_if #(
   parameter int WIDTH = cpu_pkg::WIDTH
);
   logic             imem_req_valid;
   logic             imem_req_ready;
   logic [WIDTH-1:0] imem_req_addr;
   logic             imem_rsp_valid;
   logic [WIDTH-1:0] imem_rsp_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_instr;
   logic [WIDTH-1:0] out_pc;

   modport master (
      output imem_req_valid, imem_req_addr,
      output out_valid, out_instr, out_pc,
      input  imem_req_ready, imem_rsp_valid,
      input  imem_rsp_data, out_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      input  out_valid, out_instr, out_pc,
      output imem_req_ready, imem_rsp_valid,
      output imem_rsp_data, out_ready
   );
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} entries with flush.
// Head is read straight from the storage registers.
module fetch_fifo
   import cpu_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  fetch_entry_t             din,
   input  logic                     pop,
   output fetch_entry_t             head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   fetch_entry_t    mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW:0]     count_q, count_d;
   logic            do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == FULL_CNT);
   assign count   = count_q;
   assign head    = mem_q[rd_ptr_q];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (do_push && !flush) begin
         mem_q[wr_ptr_q] <= din;
      end
   end
endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: one outstanding imem read, credit-checked against the
// fetch buffer, with redirect flush and late-response discard.
module instruction_fetch #(
   parameter int WIDTH     = cpu_pkg::WIDTH,
   parameter int BUF_DEPTH = cpu_pkg::BUF_DEPTH
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [WIDTH-1:0]    pc_address,
   output logic                pc_advance,
   input  logic                redirect,
   instruction_fetch_if.master bus
);
   import cpu_pkg::*;

   localparam int CW = $clog2(BUF_DEPTH) + 1;

   fetch_state_t     state_q, state_d;
   logic             discard_q, discard_d;
   logic [WIDTH-1:0] req_pc_q, req_pc_d;
   logic             hold_q;

   logic             hold;
   logic             credit;
   logic             req_valid;
   logic             req_fire;
   logic             rsp_in;
   logic             wait_flush;
   logic             push, pop;
   fetch_entry_t     din, head;
   logic [CW-1:0]    count;
   logic             full, empty;

   // Outputs stay quiet through the cycle following reset.
   assign hold       = rst || hold_q;
   assign pop        = !empty && bus.out_ready && !redirect && !hold;
   assign credit     = !full || pop;
   assign req_valid  = (state_q == FETCH_REQ) && !redirect
                       && credit && !hold;
   assign req_fire   = req_valid && bus.imem_req_ready;
   assign rsp_in     = (state_q == FETCH_WAIT) && bus.imem_rsp_valid;
   assign wait_flush = (state_q == FETCH_WAIT) && !bus.imem_rsp_valid
                       && redirect;
   assign push       = rsp_in && !discard_q && !redirect;
   assign din        = '{pc: req_pc_q, instr: bus.imem_rsp_data};

   always_comb begin
      state_d   = state_q;
      discard_d = discard_q;
      req_pc_d  = req_pc_q;
      unique case (1'b1)
         req_fire: begin
            state_d  = FETCH_WAIT;
            req_pc_d = pc_address;
         end
         rsp_in: begin
            state_d   = FETCH_REQ;
            discard_d = 1'b0;
         end
         wait_flush: discard_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= FETCH_REQ;
         discard_q <= 1'b0;
         req_pc_q  <= '0;
         hold_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         discard_q <= discard_d;
         req_pc_q  <= req_pc_d;
         hold_q    <= 1'b0;
      end
   end

   fetch_fifo #(
      .DEPTH (BUF_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (redirect),
      .push  (push),
      .din   (din),
      .pop   (pop),
      .head  (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   assign pc_advance         = req_fire;
   assign bus.imem_req_valid = req_valid;
   assign bus.imem_req_addr  = hold ? '0 : pc_address;
   assign bus.out_valid      = (count != '0) && !hold;
   assign bus.out_pc         = hold ? '0 : head.pc;
   assign bus.out_instr      = hold ? '0 : head.instr;
endmodule
